// File: rtl/frs_msg_queue_ctrl.sv
// -----------------------------------------------------------------------------
// frs_msg_queue_ctrl
// Multi-entry FRS (Function Readiness Status) message queue for a PCIe Root
// Port / RCEC. Received FRS messages (function ID + reason) are buffered in a
// circular buffer. The oldest entry is exposed through a 32-bit QUEUE register.
// A CTRL/STATUS register carries a sticky overflow flag, an interrupt enable
// and the empty/full status.
//
// Optional feature (macro FRS_QUEUE_WATERMARK_EN):
//   STATUS[27:16] is an RW occupancy watermark. STATUS[4] (wm_hit) is set when
//   wm != 0 and count >= wm. wm_hit also raises msg_irq.
//   Without the macro these bits read 0 and writes to them are ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   msg_valid           one received FRS message this cycle (no backpressure)
//   msg_fid, msg_reason function ID / reason code of the received message
//   csr_addr            0 = QUEUE reg, 1 = CTRL/STATUS reg
//   csr_wr_en/wdata     single-cycle CSR write strobe and data
//   csr_rdata           combinational read data selected by csr_addr
//   msg_popped          registered pulse: an entry was removed last cycle
//   msg_irq             registered level interrupt
//
// QUEUE reg  : [31:20] count, [19:16] reason, [15:0] fid. Writing bit0=1 pops.
// STATUS reg : bit0 ovf (RW1C), bit1 irq_en (RW), bit2 empty, bit3 full,
//              bit4 wm_hit and [27:16] wm when the watermark is built in.
// -----------------------------------------------------------------------------
module frs_msg_queue_ctrl #(
    parameter int DEPTH    = 16,
    parameter int FID_W    = 16,
    parameter int REASON_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                msg_valid,
    input  logic [FID_W-1:0]    msg_fid,
    input  logic [REASON_W-1:0] msg_reason,
    input  logic                csr_addr,
    input  logic                csr_wr_en,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    output logic                msg_popped,
    output logic                msg_irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Storage (contents are intentionally not reset).
    logic [FID_W-1:0]    fid_mem_r    [DEPTH];
    logic [REASON_W-1:0] reason_mem_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_r;
    logic             irq_en_r;

    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             ovf_nxt_s;
    logic             irq_en_nxt_s;

    logic             empty_s;
    logic             full_s;
    logic             q_wr_s;
    logic             st_wr_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             wm_hit_s;
    logic [31:0]      rdata_s;

    assign empty_s = (count_r == CNT_W'(0));
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign q_wr_s  = csr_wr_en & ~csr_addr;
    assign st_wr_s = csr_wr_en & csr_addr;

    // A pop on an empty queue is simply ignored.
    assign pop_s   = q_wr_s & csr_wdata[0] & ~empty_s;
    // A push into a full queue is still accepted when a pop frees a slot in
    // the same cycle; otherwise it is dropped and flagged as overflow.
    assign push_s  = msg_valid & (~full_s | pop_s);
    assign drop_s  = msg_valid & full_s & ~pop_s;

`ifdef FRS_QUEUE_WATERMARK_EN
    logic [11:0] wm_r;
    logic [11:0] wm_nxt_s;
    logic        unused_wdata_s;

    assign wm_hit_s       = (wm_r != 12'd0) && (12'(count_r) >= wm_r);
    assign unused_wdata_s = ^{csr_wdata[31:28], csr_wdata[15:2]};

    // Watermark register next-state.
    always_comb begin
        wm_nxt_s = wm_r;
        if (st_wr_s) begin
            wm_nxt_s = csr_wdata[27:16];
        end else begin
            wm_nxt_s = wm_r;
        end
    end

    // Watermark register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wm_r <= 12'd0;
        end else begin
            wm_r <= wm_nxt_s;
        end
    end
`else
    logic unused_wdata_s;

    assign wm_hit_s       = 1'b0;
    assign unused_wdata_s = ^csr_wdata[31:2];
`endif

    // Pointer, occupancy and control-flag next-state logic.
    always_comb begin
        head_nxt_s   = head_r;
        tail_nxt_s   = tail_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = ovf_r;
        irq_en_nxt_s = irq_en_r;

        if (pop_s) begin
            head_nxt_s = head_r + PTR_W'(1);
        end else begin
            head_nxt_s = head_r;
        end

        if (push_s) begin
            tail_nxt_s = tail_r + PTR_W'(1);
        end else begin
            tail_nxt_s = tail_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        // A new overflow wins over a same-cycle RW1C clear.
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (st_wr_s && csr_wdata[0]) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        if (st_wr_s) begin
            irq_en_nxt_s = csr_wdata[1];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // Control state and registered outputs. msg_irq looks at the already
    // updated register state, so it trails a state change by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            irq_en_r   <= 1'b0;
            msg_popped <= 1'b0;
            msg_irq    <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            count_r    <= count_nxt_s;
            ovf_r      <= ovf_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            msg_popped <= pop_s;
            msg_irq    <= irq_en_r & (~empty_s | ovf_r | wm_hit_s);
        end
    end

    // Message storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fid_mem_r[tail_r]    <= msg_fid;
            reason_mem_r[tail_r] <= msg_reason;
        end
    end

    // CSR read multiplexer; unused and narrower fields read as zero.
    always_comb begin
        rdata_s = 32'd0;
        if (!csr_addr) begin
            rdata_s[31:20] = 12'(count_r);
            if (!empty_s) begin
                rdata_s[16 +: REASON_W] = reason_mem_r[head_r];
                rdata_s[0 +: FID_W]     = fid_mem_r[head_r];
            end else begin
                rdata_s[19:0] = 20'd0;
            end
        end else begin
            rdata_s[0] = ovf_r;
            rdata_s[1] = irq_en_r;
            rdata_s[2] = empty_s;
            rdata_s[3] = full_s;
`ifdef FRS_QUEUE_WATERMARK_EN
            rdata_s[4]     = wm_hit_s;
            rdata_s[27:16] = wm_r;
`endif
        end
    end

    assign csr_rdata = rdata_s;

endmodule
